// File: rtl/packet_wrr_arbiter.sv
// packet_wrr_arbiter: packet-granular weighted round-robin arbiter for one
// slave port of the stream crossbar. The grant is held until the owner's
// packet ends. A winner keeps the port for up to `weight` packets before
// priority rotates.
//
// Build option: define PACKET_WRR_ARBITER_WEIGHTED_EN for per-master weights.
// If it is left undefined, weight_i is ignored, every grant loads one credit,
// and the result is plain packet round robin.
//
// Handshake: a beat moves when grant_valid_o && valid_i[id_o] && ready_i.
// That beat is the last of its packet if last_i[id_o] is also set. Only the
// owner sees ready, through s_ready_o. All other masters see 0.
module packet_wrr_arbiter #(
   parameter int S_DATA_COUNT = 4,
   parameter int WEIGHT_WIDTH = 4,
   localparam int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [S_DATA_COUNT-1:0]              valid_i,
   input  logic [S_DATA_COUNT-1:0]              last_i,
   input  logic                                 ready_i,
   input  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i,
   output logic [S_DATA_COUNT-1:0]              grant_o,
   output logic [T_ID___WIDTH-1:0]              id_o,
   output logic                                 grant_valid_o,
   output logic [S_DATA_COUNT-1:0]              s_ready_o
);

   localparam int IDW = T_ID___WIDTH;
`ifdef PACKET_WRR_ARBITER_WEIGHTED_EN
   localparam int CW = WEIGHT_WIDTH;
`else
   localparam int CW = 1;
`endif

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [CW-1:0]  credits_q, credits_d;

   // Arbitration and beat-tracking intermediates
   logic [IDW-1:0] start;
   logic [IDW-1:0] idx;
   logic [IDW-1:0] winner;
   logic           found;
   logic [CW-1:0]  w_eff;
   logic [CW-1:0]  credits_dec;
   logic           last_beat;

`ifdef PACKET_WRR_ARBITER_WEIGHTED_EN
   logic [WEIGHT_WIDTH-1:0] w_sel;
`else
   logic unused_weight;
   assign unused_weight = ^weight_i;
`endif

   // Advance an index by one, modulo S_DATA_COUNT
   function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
      if (x == IDW'(S_DATA_COUNT - 1)) return '0;
      else return x + 1'b1;
   endfunction

   // State register: FSM state, priority pointer, owner and turn credits
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         credits_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         credits_q <= credits_d;
      end
   end

   // Next state: pick a winner in IDLE, account for the packet end in BUSY
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      credits_d   = credits_q;
      winner      = '0;
      found       = 1'b0;
      credits_dec = credits_q - 1'b1;
      last_beat   = (state_q == ST_BUSY) && valid_i[owner_q] && ready_i && last_i[owner_q];

      // An owner with credit left gets first look. Otherwise the scan starts at the pointer.
      start = (credits_q != '0) ? owner_q : ptr_q;
      idx   = start;
      for (int i = 0; i < S_DATA_COUNT; i++) begin
         if (!found && valid_i[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
         idx = inc_mod(idx);
      end

`ifdef PACKET_WRR_ARBITER_WEIGHTED_EN
      w_sel = '0;
      for (int k = 0; k < S_DATA_COUNT; k++) begin
         if (winner == IDW'(k)) w_sel = weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      // A weight of zero still grants one packet.
      w_eff = (w_sel == '0) ? CW'(1) : w_sel;
`else
      w_eff = CW'(1);
`endif

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               // A new winner reloads its credits. Any turn left by a silent owner is dropped here.
               if (!((winner == owner_q) && (credits_q != '0))) credits_d = w_eff;
               owner_d = winner;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (last_beat) begin
               credits_d = credits_dec;
               if (credits_dec == '0) ptr_d = inc_mod(owner_q);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: one-hot grant from owner, routed slave ready
   always_comb begin
      grant_valid_o = (state_q == ST_BUSY);
      id_o          = owner_q;
      grant_o       = '0;
      for (int k = 0; k < S_DATA_COUNT; k++) begin
         grant_o[k] = grant_valid_o && (owner_q == IDW'(k));
      end
      s_ready_o = grant_o & {S_DATA_COUNT{ready_i && grant_valid_o}};
   end

endmodule

// File: tb/tb_packet_wrr_arbiter.sv
// Directed bench for packet_wrr_arbiter with S=4 and W=4. Expectations for
// grant order are hand-derived for either build of the weighting option.
module tb_packet_wrr_arbiter;

   localparam int S   = 4;
   localparam int W   = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [S-1:0]   valid;
   logic [S-1:0]   last;
   logic           ready;
   logic [S*W-1:0] weight;
   logic [S-1:0]   grant;
   logic [IDW-1:0] id;
   logic           grant_valid;
   logic [S-1:0]   s_ready;

   int n_checks = 0;
   int n_errors = 0;
   logic [IDW-1:0] exp_q[$];

   packet_wrr_arbiter #(.S_DATA_COUNT(S), .WEIGHT_WIDTH(W)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .valid_i(valid),
      .last_i(last),
      .ready_i(ready),
      .weight_i(weight),
      .grant_o(grant),
      .id_o(id),
      .grant_valid_o(grant_valid),
      .s_ready_o(s_ready)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = '0;
      last  = '0;
      ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // n single-beat packets with valid held at v, each checked against exp_q
   task automatic run_pkts(input logic [S-1:0] v, input int n);
      logic [IDW-1:0] e;
      logic [S-1:0]   oh;
      for (int i = 0; i < n; i++) begin
         valid = v;
         last  = '1;
         ready = 1'b1;
         check("bubble_gv", 32'(grant_valid), 32'h0);
         tick();
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'h1, 32'h0);
            e = '0;
         end else begin
            e = exp_q.pop_front();
         end
         oh = 4'b0001 << e;
         check("busy_gv", 32'(grant_valid), 32'h1);
         check("busy_id", 32'(id), 32'(e));
         check("busy_grant", 32'(grant), 32'(oh));
         check("busy_sready", 32'(s_ready), 32'(oh));
         tick();
      end
   endtask

   initial begin
      bit [7:0] vv;
      bit [7:0] rr;
      bit [7:0] ll;

      weight = {4'd1, 4'd1, 4'd1, 4'd1};
      do_reset();

      // 1: reset values and basic latency
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_id", 32'(id), 32'h0);
      check("rst_gv", 32'(grant_valid), 32'h0);
      check("rst_sready", 32'(s_ready), 32'h0);
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd2);
      run_pkts(4'b0101, 1);
      check("t1_idle_gv", 32'(grant_valid), 32'h0);
      check("t1_idle_grant", 32'(grant), 32'h0);
      valid = 4'b0101;
      tick();
      check("t1_grant2", 32'(grant), 32'b0100);
      ready = 1'b0;
      #1;
      check("t1_sready_lo", 32'(s_ready), 32'h0);
      check("t1_hold_noready", 32'(grant), 32'b0100);
      ready = 1'b1;
      #1;
      check("t1_sready_hi", 32'(s_ready), 32'b0100);
      tick();
      check("t1_release", 32'(grant_valid), 32'h0);
      exp_q.delete();

      // 2: weights {1,3,1,1}
      do_reset();
      weight = {4'd1, 4'd1, 4'd3, 4'd1};
`ifdef PACKET_WRR_ARBITER_WEIGHTED_EN
      exp_q = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
`endif
      run_pkts(4'b1111, 7);

      // 3: forfeit of master 2's remaining turn
      do_reset();
      weight = {4'd1, 4'd3, 4'd2, 4'd1};
`ifdef PACKET_WRR_ARBITER_WEIGHTED_EN
      exp_q = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
`else
      exp_q = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
`endif
      run_pkts(4'b0100, 1);
      run_pkts(4'b0010, 1);
      run_pkts(4'b0110, 5);

      // 4: hold through valid gaps and back-pressure on a 4-beat packet
      do_reset();
      weight = {4'd1, 4'd1, 4'd1, 4'd1};
      valid  = 4'b1000;
      last   = '0;
      ready  = 1'b1;
      tick();
      vv = 8'b11011011;
      rr = 8'b11001110;
      ll = 8'b10110000;
      for (int i = 0; i < 8; i++) begin
         valid = {vv[i], 3'b111};
         last  = {ll[i], 3'b000};
         ready = rr[i];
         #1;
         check("t4_hold_gv", 32'(grant_valid), 32'h1);
         check("t4_hold_grant", 32'(grant), 32'b1000);
         check("t4_sready", 32'(s_ready), 32'({rr[i], 3'b000}));
         tick();
      end
      check("t4_released", 32'(grant_valid), 32'h0);

      // 5: reset on beat 2 from master 3, then weight 0 on master 0
      do_reset();
      weight = {4'd1, 4'd1, 4'd1, 4'd0};
      valid  = 4'b1000;
      last   = '0;
      ready  = 1'b1;
      tick();
      check("t5_owner3", 32'(id), 32'h3);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_grant", 32'(grant), 32'h0);
      check("t5_rst_gv", 32'(grant_valid), 32'h0);
      check("t5_rst_id", 32'(id), 32'h0);
      check("t5_rst_sready", 32'(s_ready), 32'h0);
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      run_pkts(4'b1111, 5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/packet_wrr_arbiter.md
# packet_wrr_arbiter

- Packet-granular arbiter for one slave port of the stream crossbar. It selects one of `S_DATA_COUNT` master streams and holds the grant until that master's packet ends.
- Scheduling is weighted round robin: a winner keeps the port for up to `weight` consecutive packets before priority rotates.
- It replaces the single-packet round-robin arbiter per slave port and adds per-master weights, a rotating priority pointer, and routed `tready`.

## Interface
Parameters:
- `S_DATA_COUNT`, 4: number of masters (≥1).
- `WEIGHT_WIDTH`, 4: width of each per-master weight.
- `T_ID___WIDTH`, localparam: `max(1, $clog2(S_DATA_COUNT))`.

Ports:
- Reset/clock convention (already decided): one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset.
- `valid_i`  in  S_DATA_COUNT  tvalid of each master; also serves as its request.
- `last_i`  in  S_DATA_COUNT  tlast of each master.
- `ready_i`  in  1  tready from the slave.
- `weight_i`  in  S_DATA_COUNT*WEIGHT_WIDTH  packets per turn; master k uses slice [k*W +: W]; a value of 0 is treated as 1.
- `grant_o`  out  S_DATA_COUNT  one-hot grant.
- `id_o`  out  T_ID___WIDTH  index of the granted master.
- `grant_valid_o`  out  1  a grant is active.
- `s_ready_o`  out  S_DATA_COUNT  `grant_o & {S{ready_i && grant_valid_o}}`; this is combinational.

## Operation
- **Beat handshake:** a beat is transferred when `grant_valid_o && valid_i[id_o] && ready_i`.
- **Last beat:** a beat transferred with `last_i[id_o]=1` is the last beat of the packet.
- **Internal registers:**
  - state: IDLE or BUSY.
  - `ptr`: next search start.
  - `owner`, which drives `id_o`.
  - `credits`: WEIGHT_WIDTH bits, packets left in the current turn.
- **IDLE:**
  - Search start = `owner` if `credits≠0`, otherwise `ptr`.
  - Winner = first index with `valid_i` set, scanning start, start+1, … with wrap-around modulo S.
  - If there is no request, stay in IDLE.
  - If winner = owner and `credits≠0`: keep the existing credits.
  - Any other winner: `credits <= max(weight_i[winner],1)`.
  - Then `owner <= winner` and go to BUSY.
- **BUSY:**
  - `grant_valid_o=1`; the grant is held regardless of `valid_i` gaps (no preemption, no timeout).
  - On the last beat, `credits <= credits-1`.
  - If the result is 0, `ptr <= (owner+1) mod S`.
  - On the last beat, return to IDLE.
- **Forfeit:** if credits remain but the owner is not requesting in IDLE, the scan skips it. The new winner reloads credits, which forfeits the old owner's remaining turn.
- **Single-beat packets** (last on the first beat) are legal.

## Timing
- **Reset values:** all outputs 0 (`grant_o`, `id_o`, `grant_valid_o`, `s_ready_o`); `ptr=0`, `owner=0`, `credits=0`, state IDLE.
- **Grant latency:** a request first seen in IDLE at cycle t gives `grant_valid_o=1` at t+1.
- **Release:**
  - The last-beat handshake at cycle t drops `grant_valid_o` at t+1, which is one IDLE bubble.
  - The earliest next grant is at t+2.
- **Sampling:** weights are sampled only at a new-winner decision. A change mid-turn takes effect at the next new grant.
- **Simultaneous requests:** the lowest index at or after the search start wins.
- **Pointer wrap:** `owner=S-1` exhausted gives `ptr=0`.
- **Reset mid-packet:** `rst_i` high at cycle t forces all outputs to 0 at t+1. The interrupted packet is abandoned and is not tracked.
- **S_DATA_COUNT=1:** `id_o` is always 0, and the master is re-granted after each bubble.

## Configuration
- Macro: `PACKET_WRR_ARBITER_WEIGHTED_EN`.
- **Defined:** weighted behaviour exactly as described above.
- **Undefined:**
  - `weight_i` is ignored and every grant loads `credits=1`.
  - Priority therefore rotates after every packet (plain round robin).
  - The credit counter is reduced to a 1-bit flag.
  - Port list is unchanged.

## Test plan
All scenarios use S=4 and W=4.

1. **Reset and basic latency.** Reset, then `valid_i=0101` at t0, single-beat packets, `ready_i=1`.
   - Required: grant 0001 at t0+1; IDLE at t0+2; grant 0100 at t0+3.
   - Required: `s_ready_o` mirrors `grant_o`.
2. **Weights.** Weights {1,3,1,1}, all valid continuously, single-beat packets.
   - Required grant sequence: 0,1,1,1,2,3,0,…
   - With the macro undefined: 0,1,2,3,0,…
3. **Forfeit.** Weight[2]=3, `valid_i=0110`; master 2 gets its first turn, then drops valid during the IDLE bubble.
   - Required: the next grant goes to master 1 with credits=weight[1].
   - Required: master 2's old credits are discarded.
4. **Hold and back-pressure.** Granted master sends 4-beat packet with `valid_i` gaps and `ready_i` toggling.
   - Required: the grant is held until the 4th handshake with last.
   - Required: `s_ready_o` of non-owners stays 0 throughout.
5. **Reset mid-packet and weight 0.** `rst_i` asserted on beat 2 of a packet from master 3.
   - Required: outputs 0 next cycle; the next arbitration starts at 0.
   - Weight 0 on master 0 behaves as 1.
